// File: rtl/e_pipe_share_arbiter.sv
// rtl/e_pipe_share_arbiter.sv - round-robin sharing of one fixed-latency pipeline between requesters
// Tracks the owner of every in-flight slot and steers each pipeline result back to its issuer.
module e_pipe_share_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 8,
   parameter int LATENCY = 3
) (
   input  logic                        _i_clk,
   input  logic                        _i_rst,
   input  logic [NUM_REQ-1:0]          _i_req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   _i_req_data,
   input  logic                        _i_drain,
   output logic [NUM_REQ-1:0]          _o_req_ready,
   output logic [DATA_W-1:0]           _o_pipe_in,
   input  logic [DATA_W-1:0]           _i_pipe_out,
   output logic [NUM_REQ-1:0]          _o_resp_valid,
   output logic [DATA_W-1:0]           _o_resp_data,
   output logic                        _o_busy
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]   rr_ptr;
   logic [LATENCY-1:0] slot_valid;
   logic [PTR_W-1:0]   slot_owner [LATENCY];
   logic               grant_any;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   cand;

   // Scan starts one past the last grant so priority rotates away from the previous winner.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      if (!_i_rst && !_i_drain) begin
         for (int off = 1; off <= NUM_REQ; off++) begin
            cand = PTR_W'((int'(rr_ptr) + off) % NUM_REQ);
            if (!grant_any && _i_req_valid[cand]) begin
               grant_any = 1'b1;
               grant_idx = cand;
            end
         end
      end
   end

   always_comb begin
      _o_req_ready = '0;
      _o_pipe_in   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_any && grant_idx == PTR_W'(k)) begin
            _o_req_ready[k] = 1'b1;
            _o_pipe_in      = _i_req_data[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge _i_clk) begin
      if (_i_rst) begin
         slot_valid <= '0;
         rr_ptr     <= PTR_W'(NUM_REQ - 1);
         for (int i = 0; i < LATENCY; i++) begin
            slot_owner[i] <= '0;
         end
      end else begin
         slot_valid[0] <= grant_any;
         slot_owner[0] <= grant_idx;
         for (int i = 1; i < LATENCY; i++) begin
            slot_valid[i] <= slot_valid[i-1];
            slot_owner[i] <= slot_owner[i-1];
         end
         if (grant_any) begin
            rr_ptr <= grant_idx;
         end
      end
   end

   // The tail slot lines up with the pipeline output of the same operand.
   always_comb begin
      _o_resp_valid = '0;
      if (!_i_rst && slot_valid[LATENCY-1]) begin
         _o_resp_valid[slot_owner[LATENCY-1]] = 1'b1;
      end
   end

   assign _o_resp_data = _i_pipe_out;
   assign _o_busy      = |slot_valid;

endmodule

// File: tb/tb_e_pipe_share_arbiter.sv
// tb/tb_e_pipe_share_arbiter.sv - scoreboard bench for e_pipe_share_arbiter
// Directed scenarios followed by randomized traffic with drain and reset.
module tb_e_pipe_share_arbiter;

   localparam int N   = 2;
   localparam int DW  = 8;
   localparam int LAT = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic            drain;
   logic [N-1:0]    req_ready;
   logic [DW-1:0]   pipe_in;
   logic [DW-1:0]   pipe_out;
   logic [N-1:0]    resp_valid;
   logic [DW-1:0]   resp_data;
   logic            busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      int        due;
      int        owner;
      logic [DW-1:0] data;
   } exp_t;
   exp_t q[$];

   int          rr_m = N - 1;
   logic [N-1:0] accepted = '0;

   e_pipe_share_arbiter #(.NUM_REQ(N), .DATA_W(DW), .LATENCY(LAT)) dut (
      ._i_clk       (clk),
      ._i_rst       (rst),
      ._i_req_valid (req_valid),
      ._i_req_data  (req_data),
      ._i_drain     (drain),
      ._o_req_ready (req_ready),
      ._o_pipe_in   (pipe_in),
      ._i_pipe_out  (pipe_out),
      ._o_resp_valid(resp_valid),
      ._o_resp_data (resp_data),
      ._o_busy      (busy)
   );

   // Three-register stand-in for e_delay_3.
   logic [DW-1:0] p0 = '0, p1 = '0, p2 = '0;
   always @(posedge clk) begin
      p0 <= pipe_in;
      p1 <= p0;
      p2 <= p1;
   end
   assign pipe_out = p2;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Reference arbiter: lowest round-robin distance from the last winner wins.
   always @(negedge clk) begin
      int g;
      logic [N-1:0]  exp_rdy;
      logic [DW-1:0] exp_pin;
      g = -1;
      exp_rdy = '0;
      exp_pin = '0;
      if (!rst && !drain) begin
         for (int d = 1; d <= N && g < 0; d++) begin
            if (req_valid[(rr_m + d) % N]) g = (rr_m + d) % N;
         end
      end
      if (g >= 0) begin
         exp_rdy[g] = 1'b1;
         exp_pin = req_data[g*DW +: DW];
      end
      accepted = exp_rdy;
      tests++;
      if (req_ready !== exp_rdy) begin
         fails++;
         $display("FAIL ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_rdy);
      end
      tests++;
      if (pipe_in !== exp_pin) begin
         fails++;
         $display("FAIL pipe_in cyc=%0d got=%h want=%h", cyc, pipe_in, exp_pin);
      end
      if (g >= 0) begin
         q.push_back('{due: cyc + LAT, owner: g, data: exp_pin});
         rr_m = g;
      end
      if (rst) rr_m = N - 1;
   end

   // Response monitor: every in-flight item must come back exactly on its due cycle.
   always @(negedge clk) begin
      logic          exp_busy;
      logic [N-1:0]  exp_rv;
      logic [DW-1:0] exp_d;
      if (rst) begin
         q.delete();
      end else begin
         exp_busy = (q.size() > 0) && (q[0].due <= cyc + LAT - 1);
         tests++;
         if (busy !== exp_busy) begin
            fails++;
            $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
         end
         exp_rv = '0;
         exp_d  = '0;
         if (q.size() > 0 && q[0].due == cyc) begin
            exp_rv[q[0].owner] = 1'b1;
            exp_d = q[0].data;
         end
         tests++;
         if (resp_valid !== exp_rv) begin
            fails++;
            $display("FAIL resp_valid cyc=%0d got=%b want=%b", cyc, resp_valid, exp_rv);
         end
         if (exp_rv != '0) begin
            tests++;
            if (resp_data !== exp_d) begin
               fails++;
               $display("FAIL resp_data cyc=%0d got=%h want=%h", cyc, resp_data, exp_d);
            end
            void'(q.pop_front());
         end
      end
   end

   task automatic drive(input logic r, input logic dr, input logic [1:0] v,
                        input logic [7:0] d0, input logic [7:0] d1);
      rst       = r;
      drain     = dr;
      req_valid = v;
      req_data  = {d1, d0};
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
   endtask

   initial begin
      logic [1:0]    pend;
      logic [DW-1:0] pd [N];
      logic          r, dr;
      rst = 1'b1; drain = 1'b0; req_valid = '0; req_data = '0;
      pend = '0;
      @(posedge clk); #1;
      // 1: single request after reset
      drive(1, 0, 2'b00, 8'h00, 8'h00);
      drive(1, 0, 2'b00, 8'h00, 8'h00);
      drive(0, 0, 2'b01, 8'h01, 8'h00);
      idle(5);
      // 2: both requesters contending alternate every cycle
      for (int i = 0; i < 4; i++) drive(0, 0, 2'b11, 8'h10, 8'h20);
      idle(5);
      // 3: lone requester granted back to back
      drive(0, 0, 2'b10, 8'h00, 8'h05);
      drive(0, 0, 2'b10, 8'h00, 8'h06);
      drive(0, 0, 2'b10, 8'h00, 8'h07);
      idle(4);
      // 4: reset discards in-flight work and restores requester 0 priority
      drive(0, 0, 2'b01, 8'hAA, 8'h00);
      drive(1, 0, 2'b00, 8'h00, 8'h00);
      idle(3);
      drive(0, 0, 2'b11, 8'h44, 8'h55);
      idle(4);
      // 5: drain blocks new grants, in-flight completes
      drive(0, 0, 2'b01, 8'h33, 8'h00);
      for (int i = 0; i < 4; i++) drive(0, 1, 2'b10, 8'h00, 8'h77);
      drive(0, 0, 2'b10, 8'h00, 8'h77);
      idle(4);
      // 6: idle cycles keep the round-robin pointer
      drive(0, 0, 2'b11, 8'h61, 8'h62);
      idle(3);
      drive(0, 0, 2'b11, 8'h63, 8'h64);
      idle(4);
      // randomized traffic with valid held until accepted
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < N; k++) begin
            if (accepted[k] && req_valid[k]) pend[k] = 1'b0;
            if (!pend[k] && $urandom_range(0, 9) < 6) begin
               pend[k] = 1'b1;
               pd[k] = 8'($urandom);
            end
         end
         r  = ($urandom_range(0, 99) == 0);
         dr = ($urandom_range(0, 9) == 0);
         drive(r, dr, pend, pd[0], pd[1]);
      end
      idle(LAT + 3);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL leftover got=%0d want=0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
